rc_pwm_capture: RTL and testbench

//  Measures the high time of one RC-receiver servo PWM channel (e.g. ch5) and emits a
//  9-bit ratio 0..RATIO_MAX for consumers such as the buzzer and mode logic.

---
 rtl/rc_pwm_capture_if.sv | 10 +
 rtl/rc_pwm_capture.sv | 118 +++++++++++
 tb/tb_rc_pwm_capture.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rc_pwm_capture_if.sv
// rc_pwm_capture_if: receiver pin and ratio/status outputs of one RC PWM capture channel.
interface rc_pwm_capture_if;
    logic       pwm_in;
    logic [8:0] ratio;
    logic       valid;
    logic       update;
    logic       glitch;
    modport master (output pwm_in, input ratio, valid, update, glitch);
    modport slave  (input pwm_in, output ratio, valid, update, glitch);
endinterface

// File: rtl/rc_pwm_capture.sv
// rc_pwm_capture: measures RC servo pulse high time and converts it to a saturating ratio without a divider.
module rc_pwm_capture #(
    parameter int unsigned MIN_TICKS       = 50000,
    parameter int unsigned STEP_TICKS      = 125,
    parameter int unsigned RATIO_MAX       = 400,
    parameter int unsigned MIN_VALID_TICKS = 40000,
    parameter int unsigned MAX_VALID_TICKS = 110000,
    parameter int unsigned TIMEOUT_TICKS   = 2500000,
    parameter int unsigned FAILSAFE_RATIO  = 0
) (
    input logic              clk,
    input logic              rst_n,
    rc_pwm_capture_if.slave  pwm_if
);
    localparam int WW = $clog2(MAX_VALID_TICKS + 1) + 1;
    localparam int PW = $clog2(STEP_TICKS + 1) + 1;
    localparam int SW = $clog2(RATIO_MAX + 1) + 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1) + 1;

    typedef enum logic [1:0] {ARM, WAIT_RISE, MEASURE} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, dly_q;
    logic [WW-1:0] width_q, width_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [SW-1:0] step_q, step_d;
    logic [TW-1:0] to_q, to_d;
    logic [8:0]    ratio_q, ratio_d;
    logic          valid_q, valid_d, update_q, update_d, glitch_q, glitch_d;
    logic          rise, fall, step_wrap;

    assign rise      = sync2_q & ~dly_q;
    assign fall      = ~sync2_q & dly_q;
    assign step_wrap = pre_q == PW'(STEP_TICKS - 1);

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        pre_d    = pre_q;
        step_d   = step_q;
        ratio_d  = ratio_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        glitch_d = 1'b0;
        to_d     = (to_q == TW'(TIMEOUT_TICKS)) ? to_q : to_q + 1'b1;
        if (to_q == TW'(TIMEOUT_TICKS - 1)) begin
            valid_d = 1'b0;
            ratio_d = 9'(FAILSAFE_RATIO);
        end
        // Acceptance below overrides the timeout so a pulse landing on the expiry cycle wins.
        case (state_q)
            ARM: state_d = sync2_q ? ARM : WAIT_RISE;
            WAIT_RISE: if (rise) begin
                state_d = MEASURE;
                width_d = WW'(1);
                pre_d   = '0;
                step_d  = '0;
            end
            MEASURE: if (fall) begin
                state_d = WAIT_RISE;
                if (width_q >= WW'(MIN_VALID_TICKS)) begin
                    ratio_d  = 9'(step_q);
                    valid_d  = 1'b1;
                    update_d = 1'b1;
                    to_d     = '0;
                end else begin
                    glitch_d = 1'b1;
                end
            end else if (width_q == WW'(MAX_VALID_TICKS)) begin
                glitch_d = 1'b1;
                state_d  = ARM;
            end else begin
                width_d = width_q + 1'b1;
                if (width_q >= WW'(MIN_TICKS)) begin
                    pre_d  = step_wrap ? '0 : pre_q + 1'b1;
                    step_d = (step_wrap && step_q != SW'(RATIO_MAX)) ? step_q + 1'b1 : step_q;
                end
            end
            default: state_d = ARM;
        endcase
    end

    // Synchroniser resets high so a pin already high at reset release is not seen as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARM;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            dly_q    <= 1'b1;
            width_q  <= '0;
            pre_q    <= '0;
            step_q   <= '0;
            to_q     <= '0;
            ratio_q  <= 9'(FAILSAFE_RATIO);
            valid_q  <= 1'b0;
            update_q <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= pwm_if.pwm_in;
            sync2_q  <= sync1_q;
            dly_q    <= sync2_q;
            width_q  <= width_d;
            pre_q    <= pre_d;
            step_q   <= step_d;
            to_q     <= to_d;
            ratio_q  <= ratio_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            glitch_q <= glitch_d;
        end
    end

    assign pwm_if.ratio  = ratio_q;
    assign pwm_if.valid  = valid_q;
    assign pwm_if.update = update_q;
    assign pwm_if.glitch = glitch_q;
endmodule

// File: tb/tb_rc_pwm_capture.sv
// tb_rc_pwm_capture: directed pulse scenarios on a time-scaled capture channel with hand-computed ratios.
module tb_rc_pwm_capture;
    localparam int MIN_T = 500, STEP_T = 2, RMAX = 400, MINV = 400, MAXV = 1400, TO = 8000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0, n_bad = 0;
    int   cyc_n = 0, upd_cnt = 0, glt_cnt = 0, upd_cyc = -1, glt_cyc = -1;
    int   drop_cyc = -1, both_cnt = 0, start_cyc = 0, fall_cyc = 0;
    logic last_valid = 1'b0;

    rc_pwm_capture_if bus();

    rc_pwm_capture #(
        .MIN_TICKS(MIN_T), .STEP_TICKS(STEP_T), .RATIO_MAX(RMAX),
        .MIN_VALID_TICKS(MINV), .MAX_VALID_TICKS(MAXV),
        .TIMEOUT_TICKS(TO), .FAILSAFE_RATIO(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pwm_if(bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic p);
        @(negedge clk) bus.pwm_in = p;
        @(posedge clk) #1;
        cyc_n++;
        if (bus.update) begin upd_cnt++; upd_cyc = cyc_n; end
        if (bus.glitch) begin glt_cnt++; glt_cyc = cyc_n; end
        if (bus.update && bus.glitch) both_cnt++;
        if (last_valid && !bus.valid) drop_cyc = cyc_n;
        last_valid = bus.valid;
    endtask

    task automatic clear_mon();
        upd_cnt = 0; glt_cnt = 0; upd_cyc = -1; glt_cyc = -1;
    endtask

    task automatic pulse(input int n, input int gap);
        clear_mon();
        start_cyc = cyc_n;
        repeat (n) cyc(1'b1);
        fall_cyc = cyc_n;
        repeat (gap) cyc(1'b0);
    endtask

    task automatic test_reset();
        bus.pwm_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.ratio !== 9'd0) begin n_bad++; $display("FAIL reset_ratio got %0d want 0", bus.ratio); end
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        n_cmp++; if (bus.update !== 1'b0) begin n_bad++; $display("FAIL reset_update got %b want 0", bus.update); end
        n_cmp++; if (bus.glitch !== 1'b0) begin n_bad++; $display("FAIL reset_glitch got %b want 0", bus.glitch); end
        @(negedge clk) rst_n = 1'b1;
        clear_mon();
        repeat (10) cyc(1'b0);
        n_cmp++; if (upd_cnt + glt_cnt !== 0) begin n_bad++; $display("FAIL idle_strobes got %0d want 0", upd_cnt + glt_cnt); end
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %b want 0", bus.valid); end
    endtask

    task automatic test_nominal();
        pulse(900, 300);
        n_cmp++; if (bus.ratio !== 9'd200) begin n_bad++; $display("FAIL nominal_ratio got %0d want 200", bus.ratio); end
        n_cmp++; if (upd_cnt !== 1) begin n_bad++; $display("FAIL nominal_update_cycles got %0d want 1", upd_cnt); end
        n_cmp++; if (glt_cnt !== 0) begin n_bad++; $display("FAIL nominal_glitch got %0d want 0", glt_cnt); end
        n_cmp++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL nominal_valid got %b want 1", bus.valid); end
        n_cmp++; if (upd_cyc - fall_cyc !== 3) begin n_bad++; $display("FAIL nominal_latency got %0d want 3", upd_cyc - fall_cyc); end
    endtask

    task automatic test_boundaries();
        int w [10] = '{661, 662, 400, 663, 399, 1300, 500, 1400, 501, 1401};
        int r [10] = '{80,  81,  0,   81,  81,  400,  0,   400,  0,   0};
        int u [10] = '{1,   1,   1,   1,   0,   1,    1,   1,    1,   0};
        for (int i = 0; i < 10; i++) begin
            pulse(w[i], 300);
            n_cmp++; if (bus.ratio !== 9'(r[i])) begin n_bad++; $display("FAIL bound_ratio w=%0d got %0d want %0d", w[i], bus.ratio, r[i]); end
            n_cmp++; if (upd_cnt !== u[i]) begin n_bad++; $display("FAIL bound_update w=%0d got %0d want %0d", w[i], upd_cnt, u[i]); end
            n_cmp++; if (glt_cnt !== 1 - u[i]) begin n_bad++; $display("FAIL bound_glitch w=%0d got %0d want %0d", w[i], glt_cnt, 1 - u[i]); end
        end
    endtask

    task automatic test_short_glitch();
        pulse(900, 300);
        n_cmp++; if (bus.ratio !== 9'd200) begin n_bad++; $display("FAIL short_pre_ratio got %0d want 200", bus.ratio); end
        pulse(250, 300);
        n_cmp++; if (glt_cnt !== 1) begin n_bad++; $display("FAIL short_glitch got %0d want 1", glt_cnt); end
        n_cmp++; if (upd_cnt !== 0) begin n_bad++; $display("FAIL short_update got %0d want 0", upd_cnt); end
        n_cmp++; if (bus.ratio !== 9'd200) begin n_bad++; $display("FAIL short_ratio got %0d want 200", bus.ratio); end
    endtask

    task automatic test_stuck_high();
        pulse(1600, 300);
        n_cmp++; if (glt_cnt !== 1) begin n_bad++; $display("FAIL stuck_glitch got %0d want 1", glt_cnt); end
        n_cmp++; if (glt_cyc - start_cyc !== MAXV + 3) begin n_bad++; $display("FAIL stuck_glitch_time got %0d want %0d", glt_cyc - start_cyc, MAXV + 3); end
        n_cmp++; if (upd_cnt !== 0) begin n_bad++; $display("FAIL stuck_update got %0d want 0", upd_cnt); end
        n_cmp++; if (bus.ratio !== 9'd200) begin n_bad++; $display("FAIL stuck_ratio got %0d want 200", bus.ratio); end
        pulse(660, 300);
        n_cmp++; if (bus.ratio !== 9'd80 || upd_cnt !== 1) begin n_bad++; $display("FAIL stuck_recover got ratio %0d upd %0d want 80 1", bus.ratio, upd_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        repeat (560) cyc(1'b1);
        repeat (4) cyc(1'b0);
        repeat (100) cyc(1'b1);
        n_cmp++; if (bus.ratio !== 9'd30) begin n_bad++; $display("FAIL b2b_first_ratio got %0d want 30", bus.ratio); end
        repeat (680) cyc(1'b1);
        repeat (300) cyc(1'b0);
        n_cmp++; if (bus.ratio !== 9'd140) begin n_bad++; $display("FAIL b2b_second_ratio got %0d want 140", bus.ratio); end
        n_cmp++; if (upd_cnt !== 2 || glt_cnt !== 0) begin n_bad++; $display("FAIL b2b_strobes got upd %0d glt %0d want 2 0", upd_cnt, glt_cnt); end
    endtask

    task automatic test_timeout();
        int u;
        pulse(900, 300);
        u = upd_cyc;
        clear_mon();
        drop_cyc = -1;
        for (int i = 0; i < TO + 1000 && drop_cyc == -1; i++) cyc(1'b0);
        n_cmp++; if (drop_cyc - u !== TO) begin n_bad++; $display("FAIL timeout_time got %0d want %0d", drop_cyc - u, TO); end
        n_cmp++; if (bus.ratio !== 9'd0) begin n_bad++; $display("FAIL timeout_ratio got %0d want 0", bus.ratio); end
        n_cmp++; if (upd_cnt !== 0) begin n_bad++; $display("FAIL timeout_update got %0d want 0", upd_cnt); end
        pulse(1300, 300);
        n_cmp++; if (bus.valid !== 1'b1 || bus.ratio !== 9'd400 || upd_cnt !== 1) begin n_bad++; $display("FAIL timeout_recover got valid %b ratio %0d upd %0d want 1 400 1", bus.valid, bus.ratio, upd_cnt); end
    endtask

    task automatic test_reset_mid_pulse();
        repeat (300) cyc(1'b1);
        @(negedge clk) rst_n = 1'b0;
        repeat (3) cyc(1'b1);
        n_cmp++; if (bus.ratio !== 9'd0 || bus.valid !== 1'b0) begin n_bad++; $display("FAIL midreset_state got ratio %0d valid %b want 0 0", bus.ratio, bus.valid); end
        @(negedge clk) rst_n = 1'b1;
        clear_mon();
        repeat (600) cyc(1'b1);
        repeat (200) cyc(1'b0);
        n_cmp++; if (upd_cnt !== 0 || glt_cnt !== 0) begin n_bad++; $display("FAIL midreset_partial got upd %0d glt %0d want 0 0", upd_cnt, glt_cnt); end
        pulse(660, 300);
        n_cmp++; if (bus.ratio !== 9'd80 || upd_cnt !== 1 || bus.valid !== 1'b1) begin n_bad++; $display("FAIL midreset_recover got ratio %0d upd %0d valid %b want 80 1 1", bus.ratio, upd_cnt, bus.valid); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_boundaries();
        test_short_glitch();
        test_stuck_high();
        test_back_to_back();
        test_timeout();
        test_reset_mid_pulse();
        n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL update_with_glitch got %0d want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
